salsa_hash_stream: RTL and testbench
====================================

Name: salsa_hash_stream

Overview:
Parametrised Salsa20-family hash core, the successor to the fixed sequential Salsa hash block. Accepts a 16-word (512-bit) input block over a 32-bit load port and runs a configurable number of rounds (Salsa20/8, /12, /20) with 1 or 4 quarter-rounds per cycle. Adds the original input to the permuted state and streams the 64-byte result out in OUT_W-bit beats with backpressure. Sits between the key/nonce/counter block assembler and the keystream XOR stage.

Parameters:
ROUNDS, 20, total rounds; legal values 8, 12, 20 (must be even); ROUNDS/2 double-rounds
QR_PAR, 1, quarter-rounds evaluated per cycle; legal values 1 or 4 (4 = one full column or row round per cycle)
OUT_W, 8, output beat width in bits; legal values 8, 16, 32

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high; clears all state
start  in  1  begin a new block; sampled only when ready=1
ready  out  1  high in IDLE only
in_valid  in  1  data_in carries a valid word
in_ready  out  1  high in LOAD only
data_in  in  32  input word; word i = Salsa word x[i], little-endian
writes  out  1  data_out valid (OUT state)
out_ready  in  1  downstream accepts beat
data_out  out  OUT_W  output beat

Behaviour:
- Reset: state=IDLE, ready=1, in_ready=0, writes=0, data_out=0, word/beat/round counters=0; state and saved-input registers need not be cleared.
- Reset mid-operation (any state): return to IDLE on the next edge; the partial block is discarded and nothing further is emitted.
- IDLE: ready=1. start=1 -> LOAD next cycle. start=0 -> stay.
- LOAD: in_ready=1. Each cycle with in_valid=1 writes data_in into state x[k] and saved copy s[k]; k increments 0..15. in_valid=0 stalls, so gaps are allowed. After word 15 is accepted -> ROUND. start is ignored outside IDLE.
- ROUND: order per double-round: column QRs (0,4,8,12), (5,9,13,1), (10,14,2,6), (15,3,7,11), then row QRs (0,1,2,3), (5,6,7,4), (10,11,8,9), (15,12,13,14).
  - QR_PAR=1: one QR per cycle, in the order above.
  - QR_PAR=4: all four column QRs in one cycle, then all four row QRs in the next.
  - ROUND lasts exactly ROUNDS*4/QR_PAR cycles (80 for 20/1, 20 for 20/4, 32 for 8/1), then -> ADD.
- Quarter-round (all arithmetic mod 2^32, rotates are left rotates):
  - b ^= rotl(a+d, 7)
  - c ^= rotl(b+a, 9)
  - d ^= rotl(c+b, 13)
  - a ^= rotl(d+c, 18)
- ADD: 1 cycle; x[i] <= x[i] + s[i] mod 2^32 for all i -> OUT.
- OUT: writes=1. Beats are emitted as words 0..15, each word least-significant OUT_W bits first, giving 512/OUT_W beats (64 for OUT_W=8). A beat transfers on writes&&out_ready. out_ready=0 holds data_out and writes stable. After the last beat transfers -> IDLE, with ready=1 the following cycle.
- Latency, start accepted to first writes with no stalls: 16 + ROUNDS*4/QR_PAR + 1 + 1 cycles.
- Throughput limit: one block in flight; no overlap of LOAD with OUT.

Decomposition:
- Shared package salsa_pkg holds:
  - state enum (IDLE, LOAD, ROUND, ADD, OUT)
  - rotate constants 7/9/13/18
  - column/row QR index tables (8 entries x 4 indices)
  - function for round-cycle count from ROUNDS and QR_PAR
- Sub-module salsa_quarterround: purely combinational, 4x32 in, 4x32 out. Instantiate QR_PAR copies.
- FSM, counters and the state/saved register file live in the top module.

Test Plan:
- salsa_quarterround unit: (0x00000001,0,0,0) -> (0x08008145, 0x00000080, 0x00010200, 0x20500000); (0,0,0,0) -> all zero.
- ROUNDS=20, QR_PAR=1, OUT_W=8, all-zero input block, out_ready=1 -> 64 beats of 0x00. First writes exactly 98 cycles after start accepted; ready rises after the 64th beat.
- Random blocks across all legal ROUNDS, QR_PAR and OUT_W combinations -> output matches the software Salsa20/ROUNDS model byte-for-byte. QR_PAR=4 results are identical to QR_PAR=1, 60 cycles earlier for ROUNDS=20.
- Backpressure: out_ready toggled randomly, plus in_valid gaps during LOAD -> no lost or duplicated beats or words, and data_out is stable while stalled.
- Reset asserted at round cycle 40, then a fresh all-zero block -> writes never asserts for the aborted block; the next block yields 64 zero bytes.
- start pulsed during LOAD, ROUND and OUT -> ignored; exactly one block is produced per start accepted in IDLE.

Source files
------------

// File: rtl/salsa_pkg.sv
// salsa_pkg: shared FSM states, rotate amounts, quarter-round index tables and helpers for the Salsa hash core.
package salsa_pkg;

    typedef enum logic [2:0] {IDLE, LOAD, ROUND, ADD, OUT} state_t;

    localparam int ROT_A = 7;
    localparam int ROT_B = 9;
    localparam int ROT_C = 13;
    localparam int ROT_D = 18;

    // Entries 0..3 are the column quarter-rounds, 4..7 the row quarter-rounds; each lists (a, b, c, d).
    localparam logic [3:0] QR_IDX [8][4] = '{
        '{4'd0,  4'd4,  4'd8,  4'd12},
        '{4'd5,  4'd9,  4'd13, 4'd1},
        '{4'd10, 4'd14, 4'd2,  4'd6},
        '{4'd15, 4'd3,  4'd7,  4'd11},
        '{4'd0,  4'd1,  4'd2,  4'd3},
        '{4'd5,  4'd6,  4'd7,  4'd4},
        '{4'd10, 4'd11, 4'd8,  4'd9},
        '{4'd15, 4'd12, 4'd13, 4'd14}
    };

    function automatic int round_cycles(input int rounds, input int qr_par);
        return rounds * 4 / qr_par;
    endfunction

    function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
        return (v << n) | (v >> (32 - n));
    endfunction

endpackage

// File: rtl/salsa_quarterround.sv
// salsa_quarterround: combinational Salsa20 quarter-round; xi/xo element 0..3 = a, b, c, d.
module salsa_quarterround
    import salsa_pkg::*;
(
    input  logic [3:0][31:0] xi,
    output logic [3:0][31:0] xo
);

    logic [31:0] a, b, c, d;

    assign b  = xi[1] ^ rotl(xi[0] + xi[3], ROT_A);
    assign c  = xi[2] ^ rotl(b + xi[0], ROT_B);
    assign d  = xi[3] ^ rotl(c + b, ROT_C);
    assign a  = xi[0] ^ rotl(d + c, ROT_D);
    assign xo = {d, c, b, a};

endmodule

// File: rtl/salsa_hash_stream.sv
// salsa_hash_stream: Salsa20/ROUNDS hash with word-serial load and OUT_W-bit backpressured output stream.
module salsa_hash_stream
    import salsa_pkg::*;
#(
    parameter int ROUNDS = 20,
    parameter int QR_PAR = 1,
    parameter int OUT_W  = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic             ready,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      data_in,
    output logic             writes,
    input  logic             out_ready,
    output logic [OUT_W-1:0] data_out
);

    localparam int         RCYC   = round_cycles(ROUNDS, QR_PAR);
    localparam logic [6:0] LAST_R = 7'(RCYC - 1);
    localparam logic [1:0] LAST_B = 2'(32 / OUT_W - 1);

    state_t st, nxt;
    logic [31:0] x [16];
    logic [31:0] s [16];
    logic [3:0]  wcnt;
    logic [1:0]  bcnt;
    logic [6:0]  rcnt;
    logic [31:0] cur;
    logic        last_b;
    logic [2:0]        qe [QR_PAR];
    logic [3:0][31:0]  qo [QR_PAR];

    // One QR per cycle walks all eight table entries; four per cycle alternates column/row halves.
    for (genvar g = 0; g < QR_PAR; g++) begin : g_qr
        assign qe[g] = QR_PAR == 1 ? rcnt[2:0] : {rcnt[0], 2'(g)};
        salsa_quarterround u_qr (
            .xi({x[QR_IDX[qe[g]][3]], x[QR_IDX[qe[g]][2]], x[QR_IDX[qe[g]][1]], x[QR_IDX[qe[g]][0]]}),
            .xo(qo[g])
        );
    end

    assign last_b = bcnt == LAST_B;

    always_ff @(posedge clk)
        st <= reset ? IDLE : nxt;

    always_comb begin
        nxt = st;
        case (st)
            IDLE:    nxt = start ? LOAD : IDLE;
            LOAD:    nxt = in_valid && wcnt == 4'd15 ? ROUND : LOAD;
            ROUND:   nxt = rcnt == LAST_R ? ADD : ROUND;
            ADD:     nxt = OUT;
            OUT:     nxt = out_ready && wcnt == 4'd15 && last_b ? IDLE : OUT;
            default: nxt = IDLE;
        endcase
    end

    always_comb begin
        ready    = st == IDLE;
        in_ready = st == LOAD;
        writes   = st == OUT;
        cur      = x[wcnt] >> (OUT_W * int'(bcnt));
        data_out = writes ? cur[OUT_W-1:0] : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wcnt <= '0;
            bcnt <= '0;
            rcnt <= '0;
        end else begin
            if ((st == LOAD && in_valid) || (st == OUT && out_ready && last_b))
                wcnt <= wcnt + 4'd1;
            if (st == OUT && out_ready)
                bcnt <= last_b ? 2'd0 : bcnt + 2'd1;
            if (st == ROUND)
                rcnt <= rcnt == LAST_R ? 7'd0 : rcnt + 7'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (st == LOAD && in_valid) begin
            x[wcnt] <= data_in;
            s[wcnt] <= data_in;
        end
        if (st == ROUND)
            for (int q = 0; q < QR_PAR; q++)
                for (int j = 0; j < 4; j++)
                    x[QR_IDX[qe[q]][j]] <= qo[q][j];
        if (st == ADD)
            for (int i = 0; i < 16; i++)
                x[i] <= x[i] + s[i];
    end

endmodule

// File: tb/tb_salsa_hash_stream.sv
// tb_salsa_hash_stream: reference-model bench running several ROUNDS/QR_PAR/OUT_W configurations side by side.
module tb_salsa_hash_stream;

    localparam int NCFG = 4;
    localparam int CR [NCFG] = '{20, 20, 8, 12};
    localparam int CP [NCFG] = '{1, 4, 1, 4};
    localparam int CW [NCFG] = '{8, 8, 16, 32};

    logic clk = 1'b0;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   n_done = 0;

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] rl(input logic [31:0] v, input int n);
        return (v << n) | (v >> (32 - n));
    endfunction

    // Reference Salsa20/r core in the textbook column-then-row form.
    function automatic logic [15:0][31:0] salsa_ref(input int rounds, input logic [15:0][31:0] inb);
        logic [31:0] x [16];
        logic [15:0][31:0] r;
        for (int i = 0; i < 16; i++) x[i] = inb[i];
        for (int n = 0; n < rounds; n += 2) begin
            x[4]  ^= rl(x[0]  + x[12], 7);  x[8]  ^= rl(x[4]  + x[0],  9);
            x[12] ^= rl(x[8]  + x[4],  13); x[0]  ^= rl(x[12] + x[8],  18);
            x[9]  ^= rl(x[5]  + x[1],  7);  x[13] ^= rl(x[9]  + x[5],  9);
            x[1]  ^= rl(x[13] + x[9],  13); x[5]  ^= rl(x[1]  + x[13], 18);
            x[14] ^= rl(x[10] + x[6],  7);  x[2]  ^= rl(x[14] + x[10], 9);
            x[6]  ^= rl(x[2]  + x[14], 13); x[10] ^= rl(x[6]  + x[2],  18);
            x[3]  ^= rl(x[15] + x[11], 7);  x[7]  ^= rl(x[3]  + x[15], 9);
            x[11] ^= rl(x[7]  + x[3],  13); x[15] ^= rl(x[11] + x[7],  18);
            x[1]  ^= rl(x[0]  + x[3],  7);  x[2]  ^= rl(x[1]  + x[0],  9);
            x[3]  ^= rl(x[2]  + x[1],  13); x[0]  ^= rl(x[3]  + x[2],  18);
            x[6]  ^= rl(x[5]  + x[4],  7);  x[7]  ^= rl(x[6]  + x[5],  9);
            x[4]  ^= rl(x[7]  + x[6],  13); x[5]  ^= rl(x[4]  + x[7],  18);
            x[11] ^= rl(x[10] + x[9],  7);  x[8]  ^= rl(x[11] + x[10], 9);
            x[9]  ^= rl(x[8]  + x[11], 13); x[10] ^= rl(x[9]  + x[8],  18);
            x[12] ^= rl(x[15] + x[14], 7);  x[13] ^= rl(x[12] + x[15], 9);
            x[14] ^= rl(x[13] + x[12], 13); x[15] ^= rl(x[14] + x[13], 18);
        end
        for (int i = 0; i < 16; i++) r[i] = x[i] + inb[i];
        return r;
    endfunction

    logic [3:0][31:0] qi, qo;
    salsa_quarterround u_qr (.xi(qi), .xo(qo));

    for (genvar k = 0; k < NCFG; k++) begin : g_cfg
        localparam int R   = CR[k];
        localparam int P   = CP[k];
        localparam int W   = CW[k];
        localparam int RC  = R * 4 / P;
        localparam int LAT = 16 + RC + 2;

        logic rst, start, in_valid, out_ready, ready, in_ready, writes;
        logic [31:0]  data_in;
        logic [W-1:0] data_out, prev_d;
        logic [31:0]  expq [$];
        int acc_cyc;
        bit lat_on, seen_w, held, bp;

        salsa_hash_stream #(.ROUNDS(R), .QR_PAR(P), .OUT_W(W)) dut (
            .clk(clk), .reset(rst), .start(start), .ready(ready),
            .in_valid(in_valid), .in_ready(in_ready), .data_in(data_in),
            .writes(writes), .out_ready(out_ready), .data_out(data_out)
        );

        function automatic string nm(input string s);
            return $sformatf("cfg%0d_%s", k, s);
        endfunction

        // Expected stream: 64 little-endian bytes regrouped into W-bit beats.
        task automatic push_model(input logic [15:0][31:0] blk);
            logic [15:0][31:0] h;
            logic [7:0]  by [64];
            logic [31:0] v;
            h = salsa_ref(R, blk);
            for (int i = 0; i < 64; i++) by[i] = h[i / 4][8 * (i % 4) +: 8];
            for (int i = 0; i < 64; i += W / 8) begin
                v = '0;
                for (int j = 0; j < W / 8; j++) v |= 32'(by[i + j]) << (8 * j);
                expq.push_back(v);
            end
        endtask

        task automatic send(input logic [15:0][31:0] blk, input bit gaps, input bit push);
            int i, t;
            bit acc;
            t = 0;
            while (!ready && t < 2000) begin @(negedge clk); t++; end
            chk(nm("ready_wait"), 32'(ready), 32'd1);
            lat_on  = !gaps;
            acc_cyc = cyc;
            start   = 1'b1;
            @(negedge clk);
            start = 1'b0;
            i = 0;
            t = 0;
            while (i < 16 && t < 500) begin
                in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
                start    = gaps ? 1'($urandom_range(0, 1)) : 1'b0;
                data_in  = blk[i];
                acc      = in_valid && in_ready;
                @(negedge clk);
                if (acc) i++;
                t++;
            end
            in_valid = 1'b0;
            start    = 1'b0;
            chk(nm("words_loaded"), 32'(i), 32'd16);
            if (push) push_model(blk);
        endtask

        task automatic drain();
            int t;
            t = 0;
            while (expq.size() != 0 && t < 3000) begin
                start = bp && expq.size() > 4 ? 1'($urandom_range(0, 1)) : 1'b0;
                @(negedge clk);
                t++;
            end
            start = 1'b0;
            chk(nm("beats_left"), 32'(expq.size()), 32'd0);
            expq.delete();
            @(negedge clk);
            chk(nm("ready_after"), 32'(ready), 32'd1);
            chk(nm("writes_after"), 32'(writes), 32'd0);
            repeat (5) @(negedge clk);
            chk(nm("no_extra_load"), 32'(in_ready), 32'd0);
        endtask

        initial begin
            out_ready = 1'b1;
            held      = 1'b0;
            seen_w    = 1'b0;
            forever begin
                @(negedge clk);
                if (rst) begin
                    held   = 1'b0;
                    seen_w = 1'b0;
                end else begin
                    if (held) begin
                        chk(nm("stall_data"), 32'(data_out), 32'(prev_d));
                        chk(nm("stall_writes"), 32'(writes), 32'd1);
                    end
                    if (writes && !seen_w && lat_on) chk(nm("latency"), 32'(cyc - acc_cyc), 32'(LAT));
                    seen_w    = writes;
                    out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
                    if (writes) begin
                        if (expq.size() == 0) begin
                            n_chk++;
                            n_fail++;
                            $display("FAIL %s: got beat %h, want no output", nm("spurious"), data_out);
                        end else if (out_ready) begin
                            chk(nm("beat"), 32'(data_out), expq.pop_front());
                        end
                    end
                    held   = writes && !out_ready;
                    prev_d = data_out;
                end
            end
        end

        initial begin
            logic [15:0][31:0] blk;
            rst = 1'b1; start = 1'b0; in_valid = 1'b0; data_in = '0; bp = 1'b0; lat_on = 1'b0;
            repeat (3) @(negedge clk);
            chk(nm("rst_ready"), 32'(ready), 32'd1);
            chk(nm("rst_in_ready"), 32'(in_ready), 32'd0);
            chk(nm("rst_writes"), 32'(writes), 32'd0);
            chk(nm("rst_data"), 32'(data_out), 32'd0);
            rst = 1'b0;
            @(negedge clk);
            send('0, 1'b0, 1'b1);
            drain();
            bp = 1'b1;
            repeat (2) begin
                for (int i = 0; i < 16; i++) blk[i] = $urandom;
                send(blk, 1'b1, 1'b1);
                drain();
            end
            bp = 1'b0;
            for (int i = 0; i < 16; i++) blk[i] = $urandom;
            send(blk, 1'b0, 1'b1);
            drain();
            for (int i = 0; i < 16; i++) blk[i] = $urandom;
            send(blk, 1'b0, 1'b0);
            repeat (RC / 2) @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            chk(nm("abort_ready"), 32'(ready), 32'd1);
            chk(nm("abort_writes"), 32'(writes), 32'd0);
            repeat (RC + 20) @(negedge clk);
            send('0, 1'b0, 1'b1);
            drain();
            n_done++;
        end
    end

    initial begin
        qi = {32'd0, 32'd0, 32'd0, 32'h1};
        #1;
        chk("qr_a", qo[0], 32'h08008145);
        chk("qr_b", qo[1], 32'h00000080);
        chk("qr_c", qo[2], 32'h00010200);
        chk("qr_d", qo[3], 32'h20500000);
        qi = '0;
        #1;
        for (int i = 0; i < 4; i++) chk($sformatf("qr_zero%0d", i), qo[i], 32'h0);
        while (n_done < NCFG && cyc < 50000) @(negedge clk);
        if (n_done < NCFG) begin
            n_chk++;
            n_fail++;
            $display("FAIL timeout: got %0d configs done, want %0d", n_done, NCFG);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
